vga_scanout: RTL

- Read-side display stage. Generates SVGA 800x600@60 Hz timing (40 MHz pixel clock) and produces 4x-downscaled x_pos/y_pos read coordinates for the frame RAM wrapper.
- Takes the returned 1-bit pixel_color and drives aligned hsync/vsync/video_on/RGB to the VGA DAC pins.
- Emits a frame_end pulse at the start of vertical blank so the upstream loader and bank counter can switch banks off-screen.

---
 rtl/vga_scanout_if.sv | 29 ++
 rtl/vga_scanout.sv | 109 ++++++++++
 2 files changed

// File: rtl/vga_scanout_if.sv
// Interface between the VGA scanout stage, the frame RAM wrapper and the DAC pins.
//   master (vga_scanout): drives x_pos/y_pos, hsync/vsync/video_on, vga_r/g/b, frame_end;
//                         receives pixel_color.
//   slave  (RAM/DAC side): drives pixel_color, observes everything else.
interface vga_scanout_if #(
   parameter int unsigned X_ADDRW = 8,
   parameter int unsigned Y_ADDRW = 8
);
   logic               pixel_color;
   logic [X_ADDRW-1:0] x_pos;
   logic [Y_ADDRW-1:0] y_pos;
   logic               hsync;
   logic               vsync;
   logic               video_on;
   logic [3:0]         vga_r;
   logic [3:0]         vga_g;
   logic [3:0]         vga_b;
   logic               frame_end;

   modport master (
      input  pixel_color,
      output x_pos, y_pos, hsync, vsync, video_on, vga_r, vga_g, vga_b, frame_end
   );

   modport slave (
      output pixel_color,
      input  x_pos, y_pos, hsync, vsync, video_on, vga_r, vga_g, vga_b, frame_end
   );
endinterface

// File: rtl/vga_scanout.sv
// SVGA scanout: generates 800x600@60 timing, issues 4x-downscaled frame RAM
// read coordinates and drives sync/enable/RGB aligned with the returned pixel.
//   clk   : pixel clock (40 MHz)
//   reset : synchronous, active-high
//   bus   : vga_scanout_if.master (RAM read address/data, DAC pins, frame_end)
module vga_scanout #(
   parameter int unsigned H_VISIBLE   = 800,
   parameter int unsigned H_FRONT     = 40,
   parameter int unsigned H_SYNC      = 128,
   parameter int unsigned H_BACK      = 88,
   parameter int unsigned V_VISIBLE   = 600,
   parameter int unsigned V_FRONT     = 1,
   parameter int unsigned V_SYNC      = 4,
   parameter int unsigned V_BACK      = 23,
   parameter int unsigned WIDTH       = 200,
   parameter int unsigned HEIGHT      = 150,
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned RAM_LATENCY = 1,
   parameter bit          SYNC_POL    = 1'b1,
   parameter int unsigned X_ADDRW     = $clog2(WIDTH),
   parameter int unsigned Y_ADDRW     = $clog2(HEIGHT)
) (
   input  logic           clk,
   input  logic           reset,
   vga_scanout_if.master  bus
);

   localparam int unsigned H_CNTW      = 11;
   localparam int unsigned V_CNTW      = 10;
   localparam int unsigned WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [H_CNTW-1:0] H_LAST     = H_CNTW'(WHOLE_LINE - 1);
   localparam logic [H_CNTW-1:0] H_VIS_END  = H_CNTW'(H_VISIBLE);
   localparam logic [H_CNTW-1:0] HS_START   = H_CNTW'(H_VISIBLE + H_FRONT);
   localparam logic [H_CNTW-1:0] HS_END     = H_CNTW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [V_CNTW-1:0] V_LAST     = V_CNTW'(WHOLE_FRAME - 1);
   localparam logic [V_CNTW-1:0] V_VIS_END  = V_CNTW'(V_VISIBLE);
   localparam logic [V_CNTW-1:0] V_VIS_LAST = V_CNTW'(V_VISIBLE - 1);
   localparam logic [V_CNTW-1:0] VS_START   = V_CNTW'(V_VISIBLE + V_FRONT);
   localparam logic [V_CNTW-1:0] VS_END     = V_CNTW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [H_CNTW-1:0] h_cnt;
   logic [V_CNTW-1:0] v_cnt;

   logic vis_c;
   logic hs_c;
   logic vs_c;
   logic h_wrap_c;

   // Bit 0 is the stage-1 register; bit RAM_LATENCY lines up with pixel_color.
   logic [RAM_LATENCY:0] vis_pipe;
   logic [RAM_LATENCY:0] hs_pipe;
   logic [RAM_LATENCY:0] vs_pipe;

   // Stage-0 decode of the raster position.
   always_comb begin
      h_wrap_c = (h_cnt == H_LAST);
      vis_c    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      hs_c     = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_c     = (v_cnt >= VS_START) && (v_cnt < VS_END);
   end

   // Raster counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap_c) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Stage 1 (RAM address, frame_end), alignment pipeline and pin stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.x_pos     <= '0;
         bus.y_pos     <= '0;
         bus.frame_end <= 1'b0;
         vis_pipe      <= '0;
         hs_pipe       <= '0;
         vs_pipe       <= '0;
         bus.video_on  <= 1'b0;
         bus.hsync     <= ~SYNC_POL;
         bus.vsync     <= ~SYNC_POL;
         bus.vga_r     <= 4'h0;
         bus.vga_g     <= 4'h0;
         bus.vga_b     <= 4'h0;
      end else begin
         bus.x_pos     <= vis_c ? X_ADDRW'(h_cnt >> SCALE_SHIFT) : '0;
         bus.y_pos     <= vis_c ? Y_ADDRW'(v_cnt >> SCALE_SHIFT) : '0;
         // Fires as v_cnt steps into the first blanking line.
         bus.frame_end <= h_wrap_c && (v_cnt == V_VIS_LAST);
         vis_pipe      <= {vis_pipe[RAM_LATENCY-1:0], vis_c};
         hs_pipe       <= {hs_pipe[RAM_LATENCY-1:0], hs_c};
         vs_pipe       <= {vs_pipe[RAM_LATENCY-1:0], vs_c};
         bus.video_on  <= vis_pipe[RAM_LATENCY];
         bus.hsync     <= hs_pipe[RAM_LATENCY] ? SYNC_POL : ~SYNC_POL;
         bus.vsync     <= vs_pipe[RAM_LATENCY] ? SYNC_POL : ~SYNC_POL;
         bus.vga_r     <= (vis_pipe[RAM_LATENCY] && bus.pixel_color) ? 4'hF : 4'h0;
         bus.vga_g     <= (vis_pipe[RAM_LATENCY] && bus.pixel_color) ? 4'hF : 4'h0;
         bus.vga_b     <= (vis_pipe[RAM_LATENCY] && bus.pixel_color) ? 4'hF : 4'h0;
      end
   end

endmodule
